// File: rtl/dff_pipe_elastic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dff_pipe_elastic_pkg
//  Brief    : Shared helpers for the elastic register pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package dff_pipe_elastic_pkg;

  // Counter width able to represent 0..2*depth held entries.
  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_elastic_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dff_elastic_stage
//  Brief    : One elastic stage: main register plus skid register, so the
//             upstream ready is a flop and never depends on downstream ready.
//  Revision : 1.0 - initial release
// ============================================================================
module dff_elastic_stage #(
  parameter int                 BW_DATA = 1,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [BW_DATA-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [BW_DATA-1:0] o_data,
  input  logic               i_ready
);

  // Bit 0 doubles as "main holds data", bit 1 as "skid holds data".
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [BW_DATA-1:0] main_q, main_d;
  logic [BW_DATA-1:0] skid_q, skid_d;
  logic               ready_q, ready_d;
  logic               in_fire;
  logic               out_fire;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = (state_q != ST_EMPTY) & i_ready;

  // Next-state and register steering; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = i_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = i_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    ready_d = (state_d != ST_FULL);
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = state_q[0];
  assign o_data  = main_q;

endmodule
`default_nettype wire

// File: rtl/dff_pipe_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dff_pipe_elastic
//  Brief    : DEPTH chained elastic stages with valid/ready flow control and
//             an occupancy counter. Capacity is 2*DEPTH entries.
//  Revision : 1.0 - initial release
// ============================================================================

// Flop output delay normally comes from def_delay.v; compiled standalone the
// outputs carry no delay.
`ifndef T_DFF
`define T_DFF
`endif

module dff_pipe_elastic
  import dff_pipe_elastic_pkg::*;
#(
  parameter int                 BW_DATA = 1,
  parameter int                 DEPTH   = 2,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_flush,
  input  logic                          i_valid,
  input  logic [BW_DATA-1:0]            i_data,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic [BW_DATA-1:0]            o_data,
  input  logic                          i_ready,
  output logic [count_width(DEPTH)-1:0] o_count
);

  localparam int BW_CNT = count_width(DEPTH);

  // Handshake chain: index g is the input side of stage g, DEPTH is the output.
  logic [DEPTH:0]     valid_c;
  logic [DEPTH:0]     ready_c;
  logic [BW_DATA-1:0] data_c [DEPTH+1];

  logic [BW_CNT-1:0]  count_q, count_d;
  logic               in_fire;
  logic               out_fire;

  assign valid_c[0]     = i_valid;
  assign data_c[0]      = i_data;
  assign ready_c[DEPTH] = i_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_elastic_stage #(
      .BW_DATA (BW_DATA),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_flush (i_flush),
      .i_valid (valid_c[g]),
      .i_data  (data_c[g]),
      .o_ready (ready_c[g]),
      .o_valid (valid_c[g+1]),
      .o_data  (data_c[g+1]),
      .i_ready (ready_c[g+1])
    );
  end

  assign in_fire  = i_valid & ready_c[0];
  assign out_fire = valid_c[DEPTH] & i_ready;

  // Occupancy: +1 per accepted word, -1 per delivered word, cleared by flush.
  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + BW_CNT'(1);
    end else if (out_fire && !in_fire) begin
      count_d = count_q - BW_CNT'(1);
    end
  end

  // Occupancy register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign `T_DFF o_valid = valid_c[DEPTH];
  assign `T_DFF o_data  = data_c[DEPTH];
  assign `T_DFF o_ready = ready_c[0];
  assign `T_DFF o_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dff_pipe_elastic
//  Brief    : Self-checking bench for dff_pipe_elastic. Three instances
//             (DEPTH 3/8b, DEPTH 2/8b, DEPTH 1/32b) share one stimulus bus;
//             a FIFO-queue reference model follows the selected instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_elastic;

  localparam int          D3      = 3;
  localparam int          D2      = 2;
  localparam logic [7:0]  RV8     = 8'hA5;
  localparam logic [31:0] RV32    = 32'hA5A5_0F0F;
  localparam int          N_RAND  = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  int          sel;               // 0: DEPTH3, 1: DEPTH2, 2: DEPTH1/32b
  logic        s_valid, s_ready, s_flush;
  logic [31:0] s_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Per-instance gated inputs: unselected instances see no traffic.
  logic d3_iv, d3_ir, d3_fl, d2_iv, d2_ir, d2_fl, d1_iv, d1_ir, d1_fl;
  assign d3_iv = s_valid && (sel == 0);
  assign d3_ir = s_ready && (sel == 0);
  assign d3_fl = s_flush && (sel == 0);
  assign d2_iv = s_valid && (sel == 1);
  assign d2_ir = s_ready && (sel == 1);
  assign d2_fl = s_flush && (sel == 1);
  assign d1_iv = s_valid && (sel == 2);
  assign d1_ir = s_ready && (sel == 2);
  assign d1_fl = s_flush && (sel == 2);

  logic        d3_or, d3_ov, d2_or, d2_ov, d1_or, d1_ov;
  logic [7:0]  d3_od, d2_od;
  logic [31:0] d1_od;
  logic [2:0]  d3_cnt, d2_cnt;
  logic [1:0]  d1_cnt;

  dff_pipe_elastic #(.BW_DATA(8), .DEPTH(D3), .RST_VAL(RV8)) u_d3 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(d3_fl), .i_valid(d3_iv),
    .i_data(s_data[7:0]), .o_ready(d3_or), .o_valid(d3_ov), .o_data(d3_od),
    .i_ready(d3_ir), .o_count(d3_cnt));

  dff_pipe_elastic #(.BW_DATA(8), .DEPTH(D2), .RST_VAL(RV8)) u_d2 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(d2_fl), .i_valid(d2_iv),
    .i_data(s_data[7:0]), .o_ready(d2_or), .o_valid(d2_ov), .o_data(d2_od),
    .i_ready(d2_ir), .o_count(d2_cnt));

  dff_pipe_elastic #(.BW_DATA(32), .DEPTH(1), .RST_VAL(RV32)) u_d1 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(d1_fl), .i_valid(d1_iv),
    .i_data(s_data), .o_ready(d1_or), .o_valid(d1_ov), .o_data(d1_od),
    .i_ready(d1_ir), .o_count(d1_cnt));

  // View of the selected instance, zero-extended to 32 bits.
  logic        m_valid, m_ready;
  logic [31:0] m_data, m_count, m_in, m_rstval;
  always_comb begin
    m_valid  = d3_ov;
    m_ready  = d3_or;
    m_data   = 32'(d3_od);
    m_count  = 32'(d3_cnt);
    m_in     = 32'(s_data[7:0]);
    m_rstval = 32'(RV8);
    if (sel == 1) begin
      m_valid = d2_ov;
      m_ready = d2_or;
      m_data  = 32'(d2_od);
      m_count = 32'(d2_cnt);
    end else if (sel == 2) begin
      m_valid  = d1_ov;
      m_ready  = d1_or;
      m_data   = d1_od;
      m_count  = 32'(d1_cnt);
      m_in     = s_data;
      m_rstval = RV32;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: the pipeline as a plain FIFO of accepted words.
  logic [31:0] q[$];
  int          prev_sel  = -1;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  int          emit_cnt  = 0;

  // Mid-cycle monitor: compare DUT to model, then apply the coming edge.
  always @(negedge clk) begin
    logic in_f, out_f;
    if (!rstn) begin
      q.delete();
      hold_prev = 1'b0;
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_ready", 32'(m_ready), 32'd1);
      check("rst_count", m_count, 32'd0);
      check("rst_data",  m_data, m_rstval);
    end else begin
      if (sel != prev_sel) begin
        q.delete();
        hold_prev = 1'b0;
      end
      check("count_vs_model", m_count, 32'(q.size()));
      if (q.size() == 0) begin
        check("no_valid_when_empty", 32'(m_valid), 32'd0);
      end else if (m_valid) begin
        check("fifo_order", m_data, q[0]);
      end
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data",  m_data, hold_data);
      end
      out_f = m_valid && s_ready;
      in_f  = s_valid && m_ready;
      if (out_f && q.size() > 0) begin
        void'(q.pop_front());
        emit_cnt++;
      end
      if (s_flush) begin
        q.delete();
      end else if (in_f) begin
        q.push_back(m_in);
      end
      hold_prev = m_valid && !s_ready && !s_flush;
      hold_data = m_data;
    end
    prev_sel = sel;
  end

  int          bp_acc, sent, cyc, e0;
  logic        fire;
  logic [31:0] nextw;

  initial begin
    rstn = 1'b1; sel = 0;
    s_valid = 1'b0; s_ready = 1'b0; s_flush = 1'b0; s_data = '0;

    // Asynchronous reset: outputs settle without a clock edge.
    #1 rstn = 1'b0;
    #1;
    check("rst_d3_data",  32'(d3_od), 32'(RV8));
    check("rst_d3_ready", 32'(d3_or), 32'd1);
    check("rst_d2_valid", 32'(d2_ov), 32'd0);
    check("rst_d1_data",  d1_od, RV32);
    check("rst_d1_count", 32'(d1_cnt), 32'd0);
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Streaming through DEPTH=3: word presented in cycle 0 emerges in cycle D3,
    // then one word per cycle with no bubbles.
    s_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t < 16) begin
        s_valid = 1'b1;
        s_data  = 32'(t + 1);
        check("stream_ready", 32'(m_ready), 32'd1);
      end else begin
        s_valid = 1'b0;
      end
      if (t >= D3 && t < D3 + 16) begin
        check("stream_valid", 32'(m_valid), 32'd1);
        check("stream_data",  m_data, 32'(t - D3 + 1));
      end else begin
        check("stream_idle", 32'(m_valid), 32'd0);
      end
      step();
    end

    // Full back-pressure on DEPTH=2: exactly 2*D2 words accepted.
    sel = 1; s_ready = 1'b0;
    step();
    bp_acc = 0; nextw = 32'h40;
    for (int t = 0; t < 10; t++) begin
      s_valid = 1'b1;
      s_data  = nextw;
      fire    = m_ready;
      step();
      if (fire) begin
        bp_acc++;
        nextw = nextw + 32'd1;
      end
    end
    check("bp_accepted", 32'(bp_acc), 32'(2 * D2));
    check("bp_ready",    32'(m_ready), 32'd0);
    check("bp_count",    m_count, 32'(2 * D2));
    s_valid = 1'b0; s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(m_valid), 32'd1);
      check("drain_data",  m_data, 32'h40 + 32'(k));
      if (k < 2) check("drain_ready_low", 32'(m_ready), 32'd0);
      else       check("drain_ready_high", 32'(m_ready), 32'd1);
      step();
    end
    check("drain_empty", 32'(m_valid), 32'd0);
    check("drain_count", m_count, 32'd0);

    // Random valid/ready on DEPTH=2; the monitor scores every cycle.
    e0 = emit_cnt; sent = 0; cyc = 0;
    while (sent < N_RAND && cyc < 20000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_ready = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      fire    = s_valid && m_ready;
      step();
      if (fire) sent++;
      cyc++;
    end
    check("rand_no_timeout", 32'(cyc < 20000), 32'd1);
    s_valid = 1'b0; s_ready = 1'b1;
    repeat (8) step();
    check("rand_emitted", 32'(emit_cnt - e0), 32'(N_RAND));
    check("rand_final_count", m_count, 32'd0);

    // Flush on DEPTH=3 holding three words, with same-edge push and pop.
    sel = 0; s_ready = 1'b0; s_valid = 1'b0;
    step();
    for (int t = 0; t < 3; t++) begin
      s_valid = 1'b1;
      s_data  = 32'h11 * 32'(t + 1);
      step();
    end
    s_valid = 1'b0;
    check("pre_flush_count", m_count, 32'd3);
    s_valid = 1'b1; s_data = 32'h77; s_ready = 1'b1; s_flush = 1'b1;
    step();
    s_flush = 1'b0; s_valid = 1'b0;
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_count", m_count, 32'd0);
    check("flush_data",  m_data, 32'(RV8));
    check("flush_ready", 32'(m_ready), 32'd1);
    for (int t = 0; t < 6; t++) begin
      check("flush_no_emit", 32'(m_valid), 32'd0);
      step();
    end

    // DEPTH=1, 32-bit: capacity two, then alternating downstream ready.
    sel = 2; s_ready = 1'b0;
    step();
    for (int t = 0; t < 4; t++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      step();
    end
    check("d1_capacity_count", m_count, 32'd2);
    check("d1_capacity_ready", 32'(m_ready), 32'd0);
    for (int t = 0; t < 20; t++) begin
      s_ready = 1'(t % 2);
      if (m_ready) s_data = $urandom;
      check("d1_cap_bound", 32'(m_count <= 32'd2), 32'd1);
      step();
    end

    // Reset mid-traffic: entries dropped, outputs to reset values at once.
    check("pre_reset_busy", 32'(m_count != 32'd0), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data",  m_data, RV32);
    check("mid_rst_ready", 32'(m_ready), 32'd1);
    check("mid_rst_count", m_count, 32'd0);
    s_valid = 1'b0; s_ready = 1'b0;
    step();
    rstn = 1'b1;
    repeat (2) step();
    check("post_rst_count", m_count, 32'd0);
    check("post_rst_valid", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
